rf_port_arbiter: RTL

- Shares one single-port register file between two requesters, A and B. The register file writes when wr_en=1, otherwise does a registered read with 1-cycle latency.
- Each cycle the block picks one requester and drives that requester's command onto the register-file port. Read data is routed back to the requester that issued the read, tagged with a valid strobe.
- Sits between client engines and the storage array; it is the only master on the register-file port.

---
 rtl/rf_arb_pkg.sv | 22 ++
 rtl/rf_rr_arb2.sv | 39 +++
 rtl/rf_port_arbiter.sv | 86 ++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared definitions for the register-file port arbiter: requester indices,
// priority encoding and the default-width command record.
package rf_arb_pkg;

    localparam int unsigned REQ_A = 0;
    localparam int unsigned REQ_B = 1;

    localparam int unsigned RF_B   = 8;
    localparam int unsigned RF_ADD = 10;

    typedef enum logic {
        PRIO_A = 1'b0,
        PRIO_B = 1'b1
    } prio_t;

    typedef struct packed {
        logic              we;
        logic [RF_ADD-1:0] addr;
        logic [RF_B-1:0]   wdata;
    } rf_cmd_t;

endpackage

// File: rtl/rf_rr_arb2.sv
// Two-input arbiter: round-robin when rr_en is high, otherwise fixed priority to A.
// Produces one-hot grants and holds the priority register.
module rf_rr_arb2
    import rf_arb_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       rr_en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    prio_t prio, prio_nxt;

    always_ff @(posedge clk) begin
        if (reset) prio <= PRIO_A;
        else       prio <= prio_nxt;
    end

    always_comb begin
        gnt      = '0;
        prio_nxt = prio;
        if (!reset) begin
            case (req)
                2'b01: gnt[REQ_A] = 1'b1;
                2'b10: gnt[REQ_B] = 1'b1;
                2'b11: begin
                    if (rr_en && prio == PRIO_B) gnt[REQ_B] = 1'b1;
                    else                         gnt[REQ_A] = 1'b1;
                end
                default: gnt = '0;
            endcase
        end
        // Priority tracks the loser even in fixed mode, so switching to round-robin is deterministic.
        if (gnt[REQ_A])      prio_nxt = PRIO_B;
        else if (gnt[REQ_B]) prio_nxt = PRIO_A;
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares one single-port register file between requesters A and B, returning
// read data to the issuing requester one cycle after its grant.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int B   = 8,
    parameter int Add = 10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           rr_en,
    input  logic           req_a,
    input  logic           we_a,
    input  logic [Add-1:0] addr_a,
    input  logic [B-1:0]   wdata_a,
    output logic           gnt_a,
    output logic           rvalid_a,
    output logic [B-1:0]   rdata_a,
    input  logic           req_b,
    input  logic           we_b,
    input  logic [Add-1:0] addr_b,
    input  logic [B-1:0]   wdata_b,
    output logic           gnt_b,
    output logic           rvalid_b,
    output logic [B-1:0]   rdata_b,
    output logic           rf_wr_en,
    output logic [Add-1:0] rf_w_addr,
    output logic [Add-1:0] rf_r_addr,
    output logic [B-1:0]   rf_w_data,
    input  logic [B-1:0]   rf_r_data
);

    // Same shape as rf_cmd_t, sized by this instance's parameters.
    typedef struct packed {
        logic           we;
        logic [Add-1:0] addr;
        logic [B-1:0]   wdata;
    } cmd_t;

    logic [1:0] req, gnt;
    cmd_t       cmd_a, cmd_b, cmd_sel;
    logic       pend_a, pend_b;

    assign req   = {req_b, req_a};
    assign cmd_a = '{we: we_a, addr: addr_a, wdata: wdata_a};
    assign cmd_b = '{we: we_b, addr: addr_b, wdata: wdata_b};

    rf_rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .rr_en (rr_en),
        .req   (req),
        .gnt   (gnt)
    );

    assign gnt_a = gnt[REQ_A];
    assign gnt_b = gnt[REQ_B];

    always_comb begin
        cmd_sel = '0;
        if (gnt[REQ_A])      cmd_sel = cmd_a;
        else if (gnt[REQ_B]) cmd_sel = cmd_b;
    end

    assign rf_wr_en  = cmd_sel.we;
    assign rf_w_addr = cmd_sel.addr;
    assign rf_r_addr = cmd_sel.addr;
    assign rf_w_data = cmd_sel.wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_a <= 1'b0;
            pend_b <= 1'b0;
        end else begin
            pend_a <= gnt_a & ~we_a;
            pend_b <= gnt_b & ~we_b;
        end
    end

    // Masking with reset drops a read whose grant landed just before reset rose.
    assign rvalid_a = pend_a & ~reset;
    assign rvalid_b = pend_b & ~reset;
    assign rdata_a  = rvalid_a ? rf_r_data : '0;
    assign rdata_b  = rvalid_b ? rf_r_data : '0;

endmodule
